framebuffer_blit_engine: RTL and testbench

// - Bus initiator on the data_m memory protocol: performs word FILL and COPY into the frame buffer with no CPU load.
// - Main use is text scroll (copy rows up or down) and clear (fill with an attribute/glyph word).
// - Sits between the VGA control registers (command side) and the frame buffer CPU port (memory side).
// - Arbitration with the CPU is done by the existing bus mux; this block only sees its own access/ack.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/framebuffer_blit_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_framebuffer_blit_engine.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA block family.
// Holds the blit engine state encoding and the FILL/COPY command codes that
// the control registers and framebuffer_blit_engine agree on.
// No ports (package).
// ---------------------------------------------------------------------------
package vga_pkg;

    // Blit engine sequencing states. GAP is a one-cycle bus-idle slot placed
    // after every acknowledged access.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } blit_state_t;

    // Value of cmd_copy selecting each operation.
    localparam logic BLIT_FILL = 1'b0;
    localparam logic BLIT_COPY = 1'b1;

endpackage

// File: rtl/framebuffer_blit_engine.sv
// ---------------------------------------------------------------------------
// framebuffer_blit_engine
// Bus initiator that performs word FILL and COPY operations into the frame
// buffer, used for text scroll (copy rows up/down) and screen clear.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_copy              1 = COPY src->dst, 0 = FILL dst with cmd_fill_data
//   cmd_descending        1 = addresses decrement after each word
//   cmd_src, cmd_dst      first source / destination word address
//   cmd_count             number of words (0 completes with no bus traffic)
//   cmd_fill_data         FILL word
//   cmd_bytesel           byte enables used on every write
//   busy, done            busy from acceptance until done; done is a pulse
//   data_m_*              memory initiator port (ack registered from access)
// ---------------------------------------------------------------------------
module framebuffer_blit_engine
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH  = 19,
    parameter int COUNT_WIDTH = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_copy,
    input  logic                   cmd_descending,
    input  logic [ADDR_WIDTH-1:0]  cmd_src,
    input  logic [ADDR_WIDTH-1:0]  cmd_dst,
    input  logic [COUNT_WIDTH-1:0] cmd_count,
    input  logic [15:0]            cmd_fill_data,
    input  logic [1:0]             cmd_bytesel,
    output logic                   busy,
    output logic                   done,
    output logic                   data_m_access,
    input  logic                   data_m_ack,
    output logic [ADDR_WIDTH-1:0]  data_m_addr,
    output logic                   data_m_wr_en,
    output logic [15:0]            data_m_data_out,
    input  logic [15:0]            data_m_data_in,
    output logic [1:0]             data_m_bytesel
);

    // Next word address; wraps silently at either end of the address space.
    function automatic logic [ADDR_WIDTH-1:0] stepAddr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  down
    );
        return down ? (addr - ADDR_WIDTH'(1)) : (addr + ADDR_WIDTH'(1));
    endfunction

    blit_state_t            state_q,      state_d;
    blit_state_t            afterGap_q,   afterGap_d;
    logic                   copyMode_q,   copyMode_d;
    logic                   descending_q, descending_d;
    logic [ADDR_WIDTH-1:0]  src_q,        src_d;
    logic [ADDR_WIDTH-1:0]  dst_q,        dst_d;
    logic [COUNT_WIDTH-1:0] remaining_q,  remaining_d;
    logic [15:0]            fillData_q,   fillData_d;
    logic [1:0]             cmdBytesel_q, cmdBytesel_d;
    logic [15:0]            holdData_q,   holdData_d;

    logic                   cmdReady_q,   cmdReady_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;
    logic                   access_q,     access_d;
    logic                   wrEn_q,       wrEn_d;
    logic [ADDR_WIDTH-1:0]  addr_q,       addr_d;
    logic [15:0]            dataOut_q,    dataOut_d;
    logic [1:0]             bytesel_q,    bytesel_d;

    // Next-state logic. Every bus output is computed here one cycle ahead so
    // that all outputs leave the block straight from flops. An access is
    // launched on the edge that enters RD/WR and is held unchanged until the
    // edge that samples ack; that same edge drops access and enters GAP.
    // GAP swallows the trailing ack the responder produces because its ack is
    // registered from access; acks in IDLE/GAP/DONE are never looked at.
    always_comb begin
        state_d      = state_q;
        afterGap_d   = afterGap_q;
        copyMode_d   = copyMode_q;
        descending_d = descending_q;
        src_d        = src_q;
        dst_d        = dst_q;
        remaining_d  = remaining_q;
        fillData_d   = fillData_q;
        cmdBytesel_d = cmdBytesel_q;
        holdData_d   = holdData_q;
        cmdReady_d   = cmdReady_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        access_d     = access_q;
        wrEn_d       = wrEn_q;
        addr_d       = addr_q;
        dataOut_d    = dataOut_q;
        bytesel_d    = bytesel_q;

        case (state_q)
            IDLE: begin
                // cmd_ready comes up on the first clock after reset release,
                // and acceptance needs the registered ready so that what the
                // requester sees is what the engine honours.
                cmdReady_d = 1'b1;
                if (cmd_valid && cmdReady_q) begin
                    copyMode_d   = cmd_copy;
                    descending_d = cmd_descending;
                    src_d        = cmd_src;
                    dst_d        = cmd_dst;
                    remaining_d  = cmd_count;
                    fillData_d   = cmd_fill_data;
                    cmdBytesel_d = cmd_bytesel;
                    cmdReady_d   = 1'b0;
                    busy_d       = 1'b1;
                    if (cmd_count == '0) begin
                        state_d = DONE;
                    end else if (cmd_copy == BLIT_COPY) begin
                        state_d   = RD;
                        access_d  = 1'b1;
                        wrEn_d    = 1'b0;
                        addr_d    = cmd_src;
                        bytesel_d = 2'b11;
                    end else begin
                        state_d   = WR;
                        access_d  = 1'b1;
                        wrEn_d    = 1'b1;
                        addr_d    = cmd_dst;
                        dataOut_d = cmd_fill_data;
                        bytesel_d = cmd_bytesel;
                    end
                end
            end

            RD: begin
                if (data_m_ack) begin
                    holdData_d = data_m_data_in;
                    src_d      = stepAddr(src_q, descending_q);
                    access_d   = 1'b0;
                    afterGap_d = WR;
                    state_d    = GAP;
                end
            end

            WR: begin
                if (data_m_ack) begin
                    dst_d       = stepAddr(dst_q, descending_q);
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    access_d    = 1'b0;
                    wrEn_d      = 1'b0;
                    state_d     = GAP;
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        afterGap_d = DONE;
                    end else if (copyMode_q == BLIT_COPY) begin
                        afterGap_d = RD;
                    end else begin
                        afterGap_d = WR;
                    end
                end
            end

            GAP: begin
                // Launch whichever access comes next so it is visible in the
                // first cycle of RD/WR.
                state_d = afterGap_q;
                if (afterGap_q == RD) begin
                    access_d  = 1'b1;
                    wrEn_d    = 1'b0;
                    addr_d    = src_q;
                    bytesel_d = 2'b11;
                end else if (afterGap_q == WR) begin
                    access_d  = 1'b1;
                    wrEn_d    = 1'b1;
                    addr_d    = dst_q;
                    dataOut_d = (copyMode_q == BLIT_FILL) ? fillData_q : holdData_q;
                    bytesel_d = cmdBytesel_q;
                end
            end

            DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                cmdReady_d = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears everything at once, which
    // abandons any transfer in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            afterGap_q   <= IDLE;
            copyMode_q   <= BLIT_FILL;
            descending_q <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            remaining_q  <= '0;
            fillData_q   <= '0;
            cmdBytesel_q <= '0;
            holdData_q   <= '0;
            cmdReady_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            access_q     <= 1'b0;
            wrEn_q       <= 1'b0;
            addr_q       <= '0;
            dataOut_q    <= '0;
            bytesel_q    <= '0;
        end else begin
            state_q      <= state_d;
            afterGap_q   <= afterGap_d;
            copyMode_q   <= copyMode_d;
            descending_q <= descending_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            remaining_q  <= remaining_d;
            fillData_q   <= fillData_d;
            cmdBytesel_q <= cmdBytesel_d;
            holdData_q   <= holdData_d;
            cmdReady_q   <= cmdReady_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            access_q     <= access_d;
            wrEn_q       <= wrEn_d;
            addr_q       <= addr_d;
            dataOut_q    <= dataOut_d;
            bytesel_q    <= bytesel_d;
        end
    end

    assign cmd_ready       = cmdReady_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign data_m_access   = access_q;
    assign data_m_addr     = addr_q;
    assign data_m_wr_en    = wrEn_q;
    assign data_m_data_out = dataOut_q;
    assign data_m_bytesel  = bytesel_q;

endmodule

// File: tb/tb_framebuffer_blit_engine.sv
// ---------------------------------------------------------------------------
// tb_framebuffer_blit_engine
// Drives FILL/COPY commands into framebuffer_blit_engine, answers its bus
// with a memory responder whose ack is registered from access (optionally
// stretched), and compares the bus traffic, final memory contents and
// timing against a word-by-word reference model of the blit operation.
// ---------------------------------------------------------------------------
module tb_framebuffer_blit_engine;

    localparam int AW        = 19;
    localparam int CW        = 13;
    localparam int MEM_WORDS = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [1:0]    bsel;
    } xfer_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_copy;
    logic          cmd_descending;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [CW-1:0] cmd_count;
    logic [15:0]   cmd_fill_data;
    logic [1:0]    cmd_bytesel;
    logic          busy;
    logic          done;
    logic          data_m_access;
    logic          data_m_ack;
    logic [AW-1:0] data_m_addr;
    logic          data_m_wr_en;
    logic [15:0]   data_m_data_out;
    logic [15:0]   data_m_data_in;
    logic [1:0]    data_m_bytesel;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [MEM_WORDS];
    xfer_t       writeLog[$];
    logic [AW-1:0] readLog[$];

    int  maxDelay    = 0;
    bit  fixedDelay  = 1'b0;
    int  curDelay    = 0;
    int  waitCnt     = 0;
    int  extraCycles = 0;
    int  accessCycles = 0;
    int  doneCount   = 0;
    int  holdErrors  = 0;
    int  readBselErrors = 0;
    logic [15:0] mergeWord;

    logic          pAccess, pAck, pWrEn;
    logic [AW-1:0] pAddr;
    logic [15:0]   pData;
    logic [1:0]    pBsel;

    framebuffer_blit_engine #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_copy        (cmd_copy),
        .cmd_descending  (cmd_descending),
        .cmd_src         (cmd_src),
        .cmd_dst         (cmd_dst),
        .cmd_count       (cmd_count),
        .cmd_fill_data   (cmd_fill_data),
        .cmd_bytesel     (cmd_bytesel),
        .busy            (busy),
        .done            (done),
        .data_m_access   (data_m_access),
        .data_m_ack      (data_m_ack),
        .data_m_addr     (data_m_addr),
        .data_m_wr_en    (data_m_wr_en),
        .data_m_data_out (data_m_data_out),
        .data_m_data_in  (data_m_data_in),
        .data_m_bytesel  (data_m_bytesel)
    );

    always #5 clk = ~clk;

    // Memory responder: acks curDelay cycles late, performs the transfer once
    // on the rising ack, and keeps ack high for one more cycle (the trailing
    // ack seen in GAP) because ack is registered from access.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            data_m_ack     <= 1'b0;
            data_m_data_in <= 16'h0000;
            waitCnt  = 0;
            curDelay = 0;
        end else if (!data_m_access) begin
            data_m_ack     <= 1'b0;
            data_m_data_in <= 16'($urandom);
            waitCnt  = 0;
            curDelay = fixedDelay ? maxDelay : int'($urandom_range(maxDelay, 0));
        end else if (data_m_ack) begin
            data_m_ack <= 1'b1;
        end else if (waitCnt >= curDelay) begin
            data_m_ack <= 1'b1;
            extraCycles += curDelay;
            if (data_m_wr_en) begin
                mergeWord = mem[data_m_addr];
                if (data_m_bytesel[0]) mergeWord[7:0]  = data_m_data_out[7:0];
                if (data_m_bytesel[1]) mergeWord[15:8] = data_m_data_out[15:8];
                mem[data_m_addr] = mergeWord;
                writeLog.push_back('{data_m_addr, data_m_data_out, data_m_bytesel});
            end else begin
                data_m_data_in <= mem[data_m_addr];
                readLog.push_back(data_m_addr);
                if (data_m_bytesel != 2'b11) readBselErrors++;
            end
        end else begin
            waitCnt++;
        end
    end

    // Bus protocol watcher: an unacknowledged access must hold all of its
    // qualifiers, and an acknowledged one must drop on the next edge.
    always @(posedge clk) begin
        if (reset) begin
            pAccess = 1'b0;
            pAck    = 1'b0;
        end else begin
            if (pAccess && !pAck &&
                (!data_m_access || data_m_addr != pAddr || data_m_wr_en != pWrEn ||
                 data_m_data_out != pData || data_m_bytesel != pBsel))
                holdErrors++;
            if (pAccess && pAck && data_m_access) holdErrors++;
            if (data_m_access) accessCycles++;
            if (done) doneCount++;
            pAccess = data_m_access;
            pAck    = data_m_ack;
            pAddr   = data_m_addr;
            pWrEn   = data_m_wr_en;
            pData   = data_m_data_out;
            pBsel   = data_m_bytesel;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic scrambleCommand();
        cmd_copy       = 1'($urandom);
        cmd_descending = 1'($urandom);
        cmd_src        = AW'($urandom);
        cmd_dst        = AW'($urandom);
        cmd_count      = CW'($urandom);
        cmd_fill_data  = 16'($urandom);
        cmd_bytesel    = 2'($urandom);
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        maxDelay = 0;
        @(negedge clk);
    endtask

    // Runs one command end to end. The expected bus traffic and final memory
    // image come from replaying the blit word by word over a copy-on-write
    // overlay of the current memory; timing is 3 (FILL) or 6 (COPY) cycles
    // per word plus 2, plus whatever ack stretch the responder chose.
    task automatic applyStimulus(input string name, input bit copy, input bit desc,
                                 input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                 input int count, input logic [15:0] fill,
                                 input logic [1:0] bsel, input int dMax,
                                 input bit dFixed, input int specLat);
        logic [15:0]   ov [int];
        xfer_t         expW[$];
        logic [AW-1:0] expR[$];
        logic [AW-1:0] s, d;
        logic [15:0]   v, old;
        int            n, lat, bound, expLat;

        for (int i = 0; i < count; i++) begin
            s = desc ? src - AW'(i) : src + AW'(i);
            d = desc ? dst - AW'(i) : dst + AW'(i);
            if (copy) begin
                expR.push_back(s);
                v = ov.exists(int'(s)) ? ov[int'(s)] : mem[s];
            end else begin
                v = fill;
            end
            old = ov.exists(int'(d)) ? ov[int'(d)] : mem[d];
            ov[int'(d)] = {bsel[1] ? v[15:8] : old[15:8], bsel[0] ? v[7:0] : old[7:0]};
            expW.push_back('{d, v, bsel});
        end

        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, ".readyBeforeCmd"}, cmd_ready, 1);

        writeLog.delete();
        readLog.delete();
        maxDelay       = dMax;
        fixedDelay     = dFixed;
        extraCycles    = 0;
        accessCycles   = 0;
        doneCount      = 0;
        holdErrors     = 0;
        readBselErrors = 0;
        cmd_copy       = copy;
        cmd_descending = desc;
        cmd_src        = src;
        cmd_dst        = dst;
        cmd_count      = CW'(count);
        cmd_fill_data  = fill;
        cmd_bytesel    = bsel;
        cmd_valid      = 1'b1;
        @(posedge clk);

        // cmd_valid stays high with changing fields while busy: none of it
        // may be taken as a new command or leak into the running one.
        bound = (copy ? 6 : 3) * count * (dMax + 2) + 50;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                checkOutput({name, ".busyAfterAccept"}, busy, 1);
                checkOutput({name, ".readyWhileBusy"}, cmd_ready, 0);
            end
            if (!done) scrambleCommand();
        end while (!done && lat < bound);
        cmd_valid = 1'b0;

        checkOutput({name, ".doneSeen"}, done, 1);
        if (!done) begin
            resetDut();
        end else begin
            expLat = (copy ? 6 : 3) * count + 2 + extraCycles;
            checkOutput({name, ".latency"}, lat, expLat);
            if (specLat >= 0) checkOutput({name, ".specLatency"}, lat, specLat);
            checkOutput({name, ".busyAtDone"}, busy, 0);
            checkOutput({name, ".readyAtDone"}, cmd_ready, 1);
            @(negedge clk);
            checkOutput({name, ".donePulseWidth"}, done, 0);
            checkOutput({name, ".doneCount"}, doneCount, 1);
        end

        checkOutput({name, ".accessCycles"}, accessCycles,
                    2 * count * (copy ? 2 : 1) + extraCycles);
        checkOutput({name, ".holdRule"}, holdErrors, 0);
        checkOutput({name, ".readBytesel"}, readBselErrors, 0);
        checkOutput({name, ".writeCount"}, writeLog.size(), expW.size());
        checkOutput({name, ".readCount"}, readLog.size(), expR.size());
        for (int i = 0; i < expW.size() && i < writeLog.size(); i++)
            checkOutput($sformatf("%s.write[%0d]", name, i), writeLog[i], expW[i]);
        for (int i = 0; i < expR.size() && i < readLog.size(); i++)
            checkOutput($sformatf("%s.read[%0d]", name, i), readLog[i], expR[i]);
        foreach (ov[k])
            checkOutput($sformatf("%s.mem[%0h]", name, k), mem[k], ov[k]);
        maxDelay   = 0;
        fixedDelay = 1'b0;
    endtask

    initial begin : mainSeq
        logic [15:0] snap [80];
        int          lat;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        scrambleCommand();
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'($urandom);

        repeat (3) @(negedge clk);
        checkOutput("reset.cmd_ready", cmd_ready, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.access", data_m_access, 0);
        checkOutput("reset.wr_en", data_m_wr_en, 0);
        checkOutput("reset.addr", data_m_addr, 0);
        checkOutput("reset.data_out", data_m_data_out, 0);
        checkOutput("reset.bytesel", data_m_bytesel, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset.readyAfter", cmd_ready, 1);

        $display("[TB] FILL 0x100 x4");
        applyStimulus("fill", 1'b0, 1'b0, '0, 19'h00100, 4, 16'h1F20, 2'b11, 0, 1'b0, 14);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("fill.readback[%0d]", i), mem[32'h100 + i], 16'h1F20);

        $display("[TB] COPY row 1 -> row 0");
        for (int i = 0; i < 80; i++) snap[i] = mem[32'h50 + i];
        applyStimulus("copyUp", 1'b1, 1'b0, 19'h00050, 19'h00000, 80, 16'h0, 2'b11, 0, 1'b0, 482);
        for (int i = 0; i < 80; i++)
            checkOutput($sformatf("copyUp.row0[%0d]", i), mem[i], snap[i]);

        $display("[TB] COPY descending");
        for (int i = 0; i < 80; i++) snap[i] = mem[32'hEF - i];
        applyStimulus("copyDown", 1'b1, 1'b1, 19'h000EF, 19'h0013F, 80, 16'h0, 2'b11, 0, 1'b0, 482);
        for (int i = 0; i < 80; i++)
            checkOutput($sformatf("copyDown.dst[%0d]", i), mem[32'h13F - i], snap[i]);

        $display("[TB] count zero");
        applyStimulus("zero", 1'b1, 1'b0, 19'h00010, 19'h00020, 0, 16'h0, 2'b11, 0, 1'b0, 2);

        $display("[TB] stretched ack");
        applyStimulus("stretch", 1'b1, 1'b0, 19'h00200, 19'h00203, 6, 16'h0, 2'b11, 5, 1'b1,
                      6 * 6 + 2 + 5 * 12);
        applyStimulus("stretchFill", 1'b0, 1'b1, '0, 19'h00300, 5, 16'hA55A, 2'b01, 5, 1'b1,
                      3 * 5 + 2 + 5 * 5);

        $display("[TB] address wrap");
        applyStimulus("wrap", 1'b0, 1'b0, '0, 19'h7FFFF, 2, 16'hBEEF, 2'b11, 0, 1'b0, 8);
        checkOutput("wrap.mem0", mem[0], 16'hBEEF);

        $display("[TB] reset during COPY");
        @(negedge clk);
        cmd_copy = 1'b1; cmd_descending = 1'b0; cmd_src = 19'h00400; cmd_dst = 19'h00500;
        cmd_count = 13'd30; cmd_bytesel = 2'b11; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("midReset.busyBefore", busy, 1);
        repeat (40) @(negedge clk);
        doneCount = 0;
        reset = 1'b1;
        #1;
        checkOutput("midReset.access", data_m_access, 0);
        checkOutput("midReset.busy", busy, 0);
        checkOutput("midReset.ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lat = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) lat++;
        end
        checkOutput("midReset.noDone", lat + doneCount, 0);
        applyStimulus("afterReset", 1'b0, 1'b0, '0, 19'h00600, 7, 16'h1234, 2'b10, 0, 1'b0, 23);

        $display("[TB] random commands");
        for (int t = 0; t < 14; t++) begin
            logic [AW-1:0] rs, rd;
            rs = ($urandom_range(3, 0) == 0) ? AW'(19'h7FFE0 + $urandom_range(31, 0))
                                             : AW'($urandom_range(19'h3FF, 0));
            rd = ($urandom_range(3, 0) == 0) ? AW'(19'h7FFE0 + $urandom_range(31, 0))
                                             : AW'($urandom_range(19'h3FF, 0));
            applyStimulus($sformatf("rand%0d", t), 1'($urandom), 1'($urandom), rs, rd,
                          int'($urandom_range(40, 0)), 16'($urandom), 2'($urandom),
                          int'($urandom_range(3, 0)), 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
